// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - Nine-channel button synchroniser, debouncer and one-press arbiter.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_a,
    input  logic       raw_b,
    input  logic       raw_c,
    input  logic       raw_d,
    input  logic       raw_e,
    input  logic       raw_f,
    input  logic       raw_g,
    input  logic       raw_h,
    input  logic       raw_i,
    input  logic       freeze,
    output logic       a_button,
    output logic       b_button,
    output logic       c_button,
    output logic       d_button,
    output logic       e_button,
    output logic       f_button,
    output logic       g_button,
    output logic       h_button,
    output logic       i_button,
    output logic       multi_press,
    output logic       busy,
    output logic [3:0] press_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    logic [8:0]    raw;
    logic [8:0]    s1;
    logic [8:0]    s;
    logic [8:0]    d;
    logic [CW-1:0] cnt [9];
    logic [8:0]    cell_pulse;
    logic [3:0]    n;
    state_t        state;

    assign raw = {raw_i, raw_h, raw_g, raw_f, raw_e, raw_d, raw_c, raw_b, raw_a};
    assign {i_button, h_button, g_button, f_button, e_button,
            d_button, c_button, b_button, a_button} = cell_pulse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s  <= '0;
            d  <= '0;
            for (int i = 0; i < 9; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s  <= s1;
            // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
            for (int i = 0; i < 9; i++) begin
                if (s[i] == d[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    d[i]   <= s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        n = 4'($countones(d));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cell_pulse  <= '0;
            multi_press <= 1'b0;
            busy        <= 1'b0;
            press_count <= '0;
        end else begin
            cell_pulse  <= '0;
            multi_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (n == 4'd1) begin
                        state <= PRESSED;
                        busy  <= 1'b1;
                        // A press that starts while frozen is swallowed so it cannot fire on unfreeze.
                        if (!freeze) begin
                            cell_pulse <= d;
                            if (press_count != 4'd9) begin
                                press_count <= press_count + 4'd1;
                            end
                        end
                    end else if (n >= 4'd2) begin
                        state       <= LOCKED;
                        busy        <= 1'b1;
                        multi_press <= 1'b1;
                    end
                end
                PRESSED, LOCKED: begin
                    if (n == 4'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - Self-checking bench for button_conditioner against a sample-window model.
module tb_button_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] raw = '0;
    logic       freeze = 1'b0;
    logic       a_button, b_button, c_button, d_button, e_button;
    logic       f_button, g_button, h_button, i_button;
    logic       multi_press, busy;
    logic [3:0] press_count;
    logic [8:0] dut_pulse;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] hist[$];
    logic [8:0] md;
    logic [8:0] m_pulse;
    bit         m_multi;
    bit         m_busy;
    int         m_count;
    int         seen_cell;
    int         seen_multi;
    int         hold_len;
    int         rel_len;
    logic [8:0] sel;

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset),
        .raw_a(raw[0]), .raw_b(raw[1]), .raw_c(raw[2]), .raw_d(raw[3]), .raw_e(raw[4]),
        .raw_f(raw[5]), .raw_g(raw[6]), .raw_h(raw[7]), .raw_i(raw[8]),
        .freeze(freeze),
        .a_button(a_button), .b_button(b_button), .c_button(c_button), .d_button(d_button),
        .e_button(e_button), .f_button(f_button), .g_button(g_button), .h_button(h_button),
        .i_button(i_button),
        .multi_press(multi_press), .busy(busy), .press_count(press_count)
    );

    assign dut_pulse = {i_button, h_button, g_button, f_button, e_button,
                        d_button, c_button, b_button, a_button};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // hist[0] is the raw vector sampled at the most recent edge; cleared flops look like all-zero history.
    task automatic model_reset();
        hist = {};
        for (int k = 0; k < D + 2; k++) hist.push_front(9'h0);
        md = '0;
        m_pulse = '0;
        m_multi = 1'b0;
        m_busy = 1'b0;
        m_count = 0;
    endtask

    task automatic model_edge();
        logic [8:0] d_old;
        int n;
        bit flip;
        d_old = md;
        n = $countones(d_old);
        m_pulse = '0;
        m_multi = 1'b0;
        if (!m_busy) begin
            if (n == 1) begin
                m_busy = 1'b1;
                if (!freeze) begin
                    m_pulse = d_old;
                    if (m_count < 9) m_count++;
                end
            end else if (n >= 2) begin
                m_busy = 1'b1;
                m_multi = 1'b1;
            end
        end else if (n == 0) begin
            m_busy = 1'b0;
        end
        // The synchronised level seen at this edge is the raw sample from two edges earlier.
        for (int ch = 0; ch < 9; ch++) begin
            flip = 1'b1;
            for (int j = 1; j <= D; j++) begin
                if (hist[j][ch] == d_old[ch]) flip = 1'b0;
            end
            if (flip) md[ch] = ~d_old[ch];
        end
        hist.push_front(raw);
        void'(hist.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
        check("cycle", 32'({dut_pulse, multi_press, busy, press_count}),
              32'({m_pulse, m_multi, m_busy, 4'(m_count)}));
        seen_cell += $countones(dut_pulse);
        if (multi_press) seen_multi++;
    endtask

    task automatic ticks(input int num);
        for (int k = 0; k < num; k++) tick();
    endtask

    initial begin
        model_reset();
        seen_cell = 0;
        seen_multi = 0;
        ticks(3);
        check("reset_state", 32'({dut_pulse, multi_press, busy, press_count}), 32'h0);
        reset = 1'b1;
        ticks(3);

        // Clean press on e, released after 20 cycles.
        raw = 9'h010;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("clean_e_pulse", 32'(e_button), 32'(c == 6));
            check("clean_busy", 32'(busy), 32'(c >= 6));
        end
        raw = '0;
        ticks(12);
        check("clean_count", 32'(press_count), 32'd1);
        check("clean_total", 32'(seen_cell), 32'd1);

        // Bounce on c, then hold: pulse D+2 edges after the final rising sample.
        raw = 9'h004; tick();
        raw = 9'h000; tick();
        raw = 9'h004; tick();
        raw = 9'h000; tick();
        raw = 9'h004;
        for (int j = 0; j < 16; j++) begin
            tick();
            check("bounce_c_pulse", 32'(c_button), 32'(j == 6));
        end
        raw = '0;
        ticks(14);
        check("bounce_count", 32'(press_count), 32'd2);

        // Simultaneous a and i.
        seen_cell = 0;
        raw = 9'h101;
        ticks(15);
        check("multi_busy_held", 32'(busy), 32'd1);
        raw = '0;
        ticks(15);
        check("multi_pulses", 32'(seen_multi), 32'd1);
        check("multi_no_cell", 32'(seen_cell), 32'd0);
        check("multi_count", 32'(press_count), 32'd2);

        // Press of b that starts frozen must never fire.
        freeze = 1'b1;
        raw = 9'h002;
        ticks(12);
        freeze = 1'b0;
        ticks(10);
        raw = '0;
        ticks(14);
        check("freeze_no_pulse", 32'(seen_cell), 32'd0);
        check("freeze_count", 32'(press_count), 32'd2);
        raw = 9'h002;
        ticks(12);
        raw = '0;
        ticks(14);
        check("unfrozen_pulse", 32'(seen_cell), 32'd1);
        check("unfrozen_count", 32'(press_count), 32'd3);

        // Reset while d is held and the arbiter is busy.
        raw = 9'h008;
        for (int k = 0; k < 12 && !m_busy; k++) tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        check("async_reset_clear", 32'({dut_pulse, multi_press, busy, press_count}), 32'h0);
        ticks(2);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("post_reset_d_pulse", 32'(d_button), 32'(c == 6));
        end
        raw = '0;
        ticks(14);
        check("post_reset_count", 32'(press_count), 32'd1);

        // Saturation over 11 presses on mixed buttons.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        seen_cell = 0;
        for (int k = 1; k <= 11; k++) begin
            raw = 9'(1 << ((k * 4) % 9));
            ticks(10);
            raw = '0;
            ticks(12);
            check("sat_count", 32'(press_count), 32'(k < 9 ? k : 9));
        end
        check("sat_pulses", 32'(seen_cell), 32'd11);

        // Randomised presses with early bounce, occasional double presses and freeze.
        for (int e = 0; e < 45; e++) begin
            sel = 9'(1 << $urandom_range(0, 8));
            if ($urandom_range(0, 4) == 0) sel = sel | 9'(1 << $urandom_range(0, 8));
            freeze = ($urandom_range(0, 5) == 0);
            hold_len = $urandom_range(1, 14);
            for (int c = 0; c < hold_len; c++) begin
                raw = (c < 3 && $urandom_range(0, 2) == 0) ? 9'h000 : sel;
                tick();
            end
            raw = '0;
            rel_len = $urandom_range(1, 14);
            for (int c = 0; c < rel_len; c++) begin
                if ($urandom_range(0, 7) == 0) freeze = ~freeze;
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
